bus_arbiter: RTL and testbench

// - Round-robin arbiter owning the shared 1-bit serial main bus between NODES bus nodes.
// - Grants one requester at a time and holds the grant for one fixed-length frame:
//   4b sender + 4b receiver + 64b data + 4b CRC = 76 bit-times.
// - Drives the bus-free indication and the per-bit frame index that the nodes consume.
// - Sits directly upstream of the node array: node request lines in, grant/free/bit index out.

---
 rtl/bus_arbiter.sv | 135 +++++++++++++
 tb/tb_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared serial bus: grants one node per fixed frame,
// drives bus-free, the frame bit index and frame start/end/abort pulses.
module bus_arbiter #(
   parameter int NODES      = 16,
   parameter int FRAME_BITS = 76,
   parameter int GAP_CYCLES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [NODES-1:0] req,
   output logic [NODES-1:0] grant,
   output logic [3:0]       grant_id,
   output logic             bus_free,
   output logic [7:0]       bit_idx,
   output logic             frame_start,
   output logic             frame_end,
   output logic             frame_abort
);

   typedef enum logic [1:0] {
      IDLE,
      TX,
      GAP
   } state_t;

   localparam logic [7:0] LAST_BIT  = 8'(FRAME_BITS - 1);
   localparam logic [3:0] LAST_NODE = 4'(NODES - 1);
   localparam logic [3:0] GAP_LOAD  =
      (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

   state_t           state, state_n;
   logic [3:0]       gap_cnt, gap_n;
   logic [3:0]       last_winner, lw_n;
   logic [NODES-1:0] grant_n;
   logic [3:0]       id_n;
   logic             free_n;
   logic [7:0]       bit_n;
   logic             fs_n, fe_n, fa_n;

   logic [4:0]         base;
   logic [2*NODES-1:0] shf;
   logic [NODES-1:0]   rot;
   logic [4:0]         idx;
   logic               win_found;
   logic [3:0]         win_id;

   // Rotate requests so the node after last_winner sits at bit 0.
   always_comb begin
      base = (last_winner == LAST_NODE) ? 5'd0
                                        : {1'b0, last_winner} + 5'd1;
      shf = {req, req} >> base;
      rot = shf[NODES-1:0];
      win_found = 1'b0;
      idx = 5'd0;
      for (int i = NODES - 1; i >= 0; i--) begin
         if (rot[i]) begin
            win_found = 1'b1;
            idx = base + 5'(i);
         end
      end
      win_id = (idx >= 5'(NODES)) ? 4'(idx - 5'(NODES)) : idx[3:0];
   end

   always_comb begin
      state_n = state;
      gap_n   = gap_cnt;
      lw_n    = last_winner;
      grant_n = '0;
      id_n    = 4'd0;
      bit_n   = 8'd0;
      fs_n    = 1'b0;
      fe_n    = 1'b0;
      fa_n    = 1'b0;
      unique case (state)
         IDLE: begin
            if (win_found) begin
               state_n = TX;
               grant_n = {{(NODES-1){1'b0}}, 1'b1} << win_id;
               id_n    = win_id;
               lw_n    = win_id;
               fs_n    = 1'b1;
               fe_n    = (LAST_BIT == 8'd0);
            end
         end
         TX: begin
            if (bit_idx == LAST_BIT || !(|(req & grant))) begin
               fa_n  = (bit_idx != LAST_BIT);
               gap_n = GAP_LOAD;
               state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
            end else begin
               grant_n = grant;
               id_n    = grant_id;
               bit_n   = bit_idx + 8'd1;
               fe_n    = (bit_idx + 8'd1 == LAST_BIT);
            end
         end
         GAP: begin
            if (gap_cnt == 4'd0) begin
               state_n = IDLE;
            end else begin
               gap_n = gap_cnt - 4'd1;
            end
         end
         default: state_n = IDLE;
      endcase
      free_n = (state_n == IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         gap_cnt     <= 4'd0;
         last_winner <= LAST_NODE;
         grant       <= '0;
         grant_id    <= 4'd0;
         bus_free    <= 1'b1;
         bit_idx     <= 8'd0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         state       <= state_n;
         gap_cnt     <= gap_n;
         last_winner <= lw_n;
         grant       <= grant_n;
         grant_id    <= id_n;
         bus_free    <= free_n;
         bit_idx     <= bit_n;
         frame_start <= fs_n;
         frame_end   <= fe_n;
         frame_abort <= fa_n;
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with literal checks plus
// randomized traffic compared every cycle against a frame-level model.
module tb_bus_arbiter;

   localparam int NODES = 16;
   localparam int FB    = 76;
   localparam int GAP   = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] req   = '0;
   logic [15:0] grant;
   logic [3:0]  grant_id;
   logic        bus_free;
   logic [7:0]  bit_idx;
   logic        frame_start, frame_end, frame_abort;

   bus_arbiter #(.NODES(NODES), .FRAME_BITS(FB), .GAP_CYCLES(GAP)) dut (
      .clock(clock), .reset(reset), .req(req),
      .grant(grant), .grant_id(grant_id), .bus_free(bus_free),
      .bit_idx(bit_idx), .frame_start(frame_start),
      .frame_end(frame_end), .frame_abort(frame_abort)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Model: owner (-1 none), bit position, remaining gap cycles, last winner
   int m_owner = -1;
   int m_bit   = 0;
   int m_gap   = 0;
   int m_last  = NODES - 1;
   bit m_fs    = 0;
   bit m_fa    = 0;
   bit m_valid = 0;

   always @(posedge clock) begin
      int c;
      cyc++;
      m_fs = 0;
      m_fa = 0;
      if (reset) begin
         m_owner = -1; m_bit = 0; m_gap = 0; m_last = NODES - 1;
      end else if (m_owner >= 0) begin
         if (m_bit == FB - 1) begin
            m_owner = -1; m_gap = GAP;
         end else if (!req[m_owner]) begin
            m_owner = -1; m_gap = GAP; m_fa = 1;
         end else begin
            m_bit++;
         end
      end else if (m_gap > 0) begin
         m_gap--;
      end else begin
         for (int k = 1; k <= NODES; k++) begin
            c = (m_last + k) % NODES;
            if (m_owner < 0 && req[c]) begin
               m_owner = c; m_last = c; m_bit = 0; m_fs = 1;
            end
         end
      end
      m_valid = 1;
   end

   always @(negedge clock) begin
      logic [15:0] eg;
      logic [3:0]  eid;
      logic [7:0]  eb;
      logic        ef, efe;
      if (m_valid) begin
         eg  = (m_owner >= 0) ? (16'd1 << m_owner) : 16'd0;
         eid = (m_owner >= 0) ? 4'(m_owner) : 4'd0;
         eb  = (m_owner >= 0) ? 8'(m_bit) : 8'd0;
         ef  = (m_owner < 0) && (m_gap == 0);
         efe = (m_owner >= 0) && (m_bit == FB - 1);
         checks++;
         if ({grant, grant_id, bus_free, bit_idx,
              frame_start, frame_end, frame_abort} !==
             {eg, eid, ef, eb, m_fs, efe, m_fa}) begin
            failures++;
            $display("FAIL model cyc=%0d grant=%h/%h id=%0d/%0d free=%b/%b bit=%0d/%0d fs=%b/%b fe=%b/%b fa=%b/%b",
                     cyc, grant, eg, grant_id, eid, bus_free, ef,
                     bit_idx, eb, frame_start, m_fs, frame_end, efe,
                     frame_abort, m_fa);
         end
         checks++;
         if ($countones(grant) > 1 ||
             (grant != 16'd0 && grant != (16'd1 << grant_id))) begin
            failures++;
            $display("FAIL onehot cyc=%0d grant=%h id=%0d", cyc, grant, grant_id);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string name);
      chk({name, "_grant"}, int'(grant), 0);
      chk({name, "_id"}, int'(grant_id), 0);
      chk({name, "_free"}, int'(bus_free), 1);
      chk({name, "_bit"}, int'(bit_idx), 0);
      chk({name, "_pulses"},
          int'({frame_start, frame_end, frame_abort}), 0);
   endtask

   task automatic wait_start(output int id, output int at);
      id = -1;
      at = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if (frame_start === 1'b1) begin
            id = int'(grant_id);
            at = cyc;
            return;
         end
      end
      failures++;
      $display("FAIL wait_start timeout at cyc=%0d", cyc);
   endtask

   task automatic wait_bit(input int b);
      for (int i = 0; i < 300; i++) begin
         if (bit_idx == 8'(b) && grant != 16'd0) return;
         @(negedge clock);
      end
      failures++;
      $display("FAIL wait_bit%0d timeout at cyc=%0d", b, cyc);
   endtask

   task automatic wait_end();
      for (int i = 0; i < 300; i++) begin
         if (frame_end === 1'b1) return;
         @(negedge clock);
      end
      failures++;
      $display("FAIL wait_end timeout at cyc=%0d", cyc);
   endtask

   int fair_ids[5] = '{0, 3, 9, 0, 3};

   initial begin
      int id, at, prev;
      // Reset with random requests
      repeat (3) begin
         req = 16'($urandom);
         @(negedge clock);
      end
      chk_reset_vals("reset");

      // Single request from node 5
      reset = 1'b0;
      req = 16'h0020;
      @(negedge clock);
      chk("single_grant", int'(grant), 32'h0020);
      chk("single_id", int'(grant_id), 5);
      chk("single_fs", int'(frame_start), 1);
      repeat (75) @(negedge clock);
      chk("single_bit75", int'(bit_idx), 75);
      chk("single_fe", int'(frame_end), 1);
      @(negedge clock);
      chk("gap1_free", int'(bus_free), 0);
      chk("gap1_grant", int'(grant), 0);
      @(negedge clock);
      chk("gap2_free", int'(bus_free), 0);
      chk("gap2_grant", int'(grant), 0);
      @(negedge clock);
      chk("idle_free", int'(bus_free), 1);
      @(negedge clock);
      chk("regrant", int'(grant), 32'h0020);
      chk("regrant_fs", int'(frame_start), 1);

      // Fairness among nodes 0, 3, 9
      reset = 1'b1;
      req = 16'h0209;
      @(negedge clock);
      reset = 1'b0;
      prev = 0;
      for (int k = 0; k < 5; k++) begin
         wait_start(id, at);
         chk($sformatf("fair_id%0d", k), id, fair_ids[k]);
         if (k > 0) chk($sformatf("fair_period%0d", k), at - prev, FB + GAP + 1);
         prev = at;
      end

      // Abort: node 7 drops at bit 30
      req = 16'h0080;
      wait_start(id, at);
      chk("abort_owner", id, 7);
      wait_bit(30);
      req = 16'h0204;
      @(negedge clock);
      chk("abort_pulse", int'(frame_abort), 1);
      chk("abort_grant", int'(grant), 0);
      chk("abort_no_fe", int'(frame_end), 0);
      chk("abort_bit", int'(bit_idx), 0);
      wait_start(id, at);
      chk("after_abort_id", id, 9);

      // Reset in the middle of a frame
      req = 16'h0004;
      wait_start(id, at);
      chk("midreset_owner", id, 2);
      wait_bit(40);
      reset = 1'b1;
      @(negedge clock);
      chk_reset_vals("midreset");
      reset = 1'b0;
      req = 16'h0005;
      wait_start(id, at);
      chk("post_reset_id", id, 0);

      // Late request rising during the gap
      wait_end();
      @(negedge clock);
      req = 16'h0010;
      @(negedge clock);
      chk("late_gap_free", int'(bus_free), 0);
      chk("late_gap_grant", int'(grant), 0);
      @(negedge clock);
      chk("late_idle_free", int'(bus_free), 1);
      chk("late_idle_grant", int'(grant), 0);
      @(negedge clock);
      chk("late_id", int'(grant_id), 4);
      chk("late_free", int'(bus_free), 0);
      chk("late_fs", int'(frame_start), 1);

      // Randomized traffic against the model
      repeat (4000) begin
         @(negedge clock);
         if ($urandom_range(0, 19) == 0)
            req = 16'($urandom) & 16'($urandom);
         reset = ($urandom_range(0, 399) == 0);
      end
      reset = 1'b0;
      @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
